// File: rtl/instr_register_pkg.sv
// Shared definitions for the instruction register: opcode encoding and the
// bit position of the divide-by-zero flag within a stored entry.
package instr_register_pkg;

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    // div0 is the last field of an entry, so it lands in the LSB.
    localparam int DIV0_POS = 0;

endpackage

// File: rtl/instr_alu.sv
// Combinational calculator for one instruction entry. Operands are
// sign-extended to the result width before any operation.
module instr_alu
    import instr_register_pkg::*;
#(
    parameter int OP_WIDTH  = 32,
    parameter int RES_WIDTH = 2 * OP_WIDTH
) (
    input  opcode_t                     opcode,
    input  logic signed [OP_WIDTH-1:0]  a,
    input  logic signed [OP_WIDTH-1:0]  b,
    output logic signed [RES_WIDTH-1:0] result,
    output logic                        div0
);

    logic signed [RES_WIDTH-1:0] a_ext;
    logic signed [RES_WIDTH-1:0] b_ext;
    logic                        b_zero;

    assign a_ext  = {{(RES_WIDTH-OP_WIDTH){a[OP_WIDTH-1]}}, a};
    assign b_ext  = {{(RES_WIDTH-OP_WIDTH){b[OP_WIDTH-1]}}, b};
    assign b_zero = (b == '0);

    // SV signed / truncates toward zero and % follows the dividend's sign.
    always_comb begin
        result = '0;
        div0   = 1'b0;
        case (opcode)
            ZERO:  result = '0;
            PASSA: result = a_ext;
            PASSB: result = b_ext;
            ADD:   result = a_ext + b_ext;
            SUB:   result = a_ext - b_ext;
            MULT:  result = a_ext * b_ext;
            DIV: begin
                if (b_zero) div0 = 1'b1;
                else        result = a_ext / b_ext;
            end
            MOD: begin
                if (b_zero) div0 = 1'b1;
                else        result = a_ext % b_ext;
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/instr_register_alu.sv
// Instruction register with a two-stage compute-and-write pipeline and a
// registered, write-first read port with per-entry valid tracking.
module instr_register_alu
    import instr_register_pkg::*;
#(
    parameter int OP_WIDTH  = 32,
    parameter int DEPTH     = 32,
    parameter int RES_WIDTH = 2 * OP_WIDTH,
    localparam int AW       = $clog2(DEPTH),
    localparam int ENTRY_W  = 3 + 2 * OP_WIDTH + RES_WIDTH + 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       load_en,
    input  logic [AW-1:0]              write_pointer,
    input  opcode_t                    opcode,
    input  logic signed [OP_WIDTH-1:0] operand_a,
    input  logic signed [OP_WIDTH-1:0] operand_b,
    input  logic                       clear,
    input  logic                       rd_en,
    input  logic [AW-1:0]              read_pointer,
    output logic                       rd_valid,
    output logic [ENTRY_W-1:0]         instruction_word,
    output logic                       entry_valid,
    output logic [AW:0]                write_count
);

    typedef logic signed [OP_WIDTH-1:0] operand_t;

    typedef struct packed {
        opcode_t                     opc;
        operand_t                    op_a;
        operand_t                    op_b;
        logic signed [RES_WIDTH-1:0] result;
        logic                        div0;
    } entry_t;

    entry_t     mem [DEPTH];
    logic [DEPTH-1:0] valid;

    logic       s1_valid;
    logic [AW-1:0] s1_ptr;
    opcode_t    s1_opc;
    operand_t   s1_a;
    operand_t   s1_b;

    logic signed [RES_WIDTH-1:0] alu_result;
    logic       alu_div0;
    entry_t     commit_entry;
    logic       commit;

    // Stage 1 capture; a clear does not cancel a capture on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_ptr   <= '0;
            s1_opc   <= ZERO;
            s1_a     <= '0;
            s1_b     <= '0;
        end else begin
            s1_valid <= load_en;
            if (load_en) begin
                s1_ptr <= write_pointer;
                s1_opc <= opcode;
                s1_a   <= operand_a;
                s1_b   <= operand_b;
            end
        end
    end

    instr_alu #(
        .OP_WIDTH  (OP_WIDTH),
        .RES_WIDTH (RES_WIDTH)
    ) u_alu (
        .opcode (s1_opc),
        .a      (s1_a),
        .b      (s1_b),
        .result (alu_result),
        .div0   (alu_div0)
    );

    always_comb begin
        commit_entry.opc    = s1_opc;
        commit_entry.op_a   = s1_a;
        commit_entry.op_b   = s1_b;
        commit_entry.result = alu_result;
        commit_entry.div0   = alu_div0;
    end

    // A clear on the commit edge discards the stage-2 write entirely.
    assign commit = s1_valid && !clear;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (commit) begin
            mem[s1_ptr] <= commit_entry;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid       <= '0;
            write_count <= '0;
        end else if (clear) begin
            valid       <= '0;
            write_count <= '0;
        end else if (commit) begin
            valid[s1_ptr] <= 1'b1;
            if (!valid[s1_ptr] && write_count != (AW+1)'(DEPTH))
                write_count <= write_count + 1'b1;
        end
    end

    // Write-first read: a commit to the same address on this edge wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid         <= 1'b0;
            instruction_word <= '0;
            entry_valid      <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                if (commit && s1_ptr == read_pointer) begin
                    instruction_word <= commit_entry;
                    entry_valid      <= 1'b1;
                end else if (valid[read_pointer]) begin
                    instruction_word <= mem[read_pointer];
                    entry_valid      <= 1'b1;
                end else begin
                    instruction_word <= '0;
                    entry_valid      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_register_alu.sv
// Directed scoreboard bench for instr_register_alu: expected read results are
// queued as reads are issued and compared when the read response arrives.
module tb_instr_register_alu;
    import instr_register_pkg::*;

    localparam int OP_WIDTH  = 32;
    localparam int DEPTH     = 32;
    localparam int RES_WIDTH = 64;
    localparam int AW        = 5;
    localparam int ENTRY_W   = 3 + 2 * OP_WIDTH + RES_WIDTH + 1;

    typedef struct packed {
        logic               ev;
        logic [ENTRY_W-1:0] word;
    } exp_t;

    logic                       clk;
    logic                       reset_n;
    logic                       load_en;
    logic [AW-1:0]              write_pointer;
    opcode_t                    opcode;
    logic signed [OP_WIDTH-1:0] operand_a;
    logic signed [OP_WIDTH-1:0] operand_b;
    logic                       clear;
    logic                       rd_en;
    logic [AW-1:0]              read_pointer;
    logic                       rd_valid;
    logic [ENTRY_W-1:0]         instruction_word;
    logic                       entry_valid;
    logic [AW:0]                write_count;

    exp_t exp_q[$];
    int   checks;
    int   failures;

    instr_register_alu #(
        .OP_WIDTH  (OP_WIDTH),
        .DEPTH     (DEPTH),
        .RES_WIDTH (RES_WIDTH)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .load_en          (load_en),
        .write_pointer    (write_pointer),
        .opcode           (opcode),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .clear            (clear),
        .rd_en            (rd_en),
        .read_pointer     (read_pointer),
        .rd_valid         (rd_valid),
        .instruction_word (instruction_word),
        .entry_valid      (entry_valid),
        .write_count      (write_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [ENTRY_W-1:0] make_word(opcode_t o,
                                                     logic signed [OP_WIDTH-1:0] a,
                                                     logic signed [OP_WIDTH-1:0] b,
                                                     logic signed [RES_WIDTH-1:0] r,
                                                     logic d);
        return {o, a, b, r, d};
    endfunction

    task automatic checkOutput(input string tag, input logic [ENTRY_W-1:0] obs,
                               input logic [ENTRY_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expectRead(input logic ev, input logic [ENTRY_W-1:0] word);
        exp_t e;
        e.ev   = ev;
        e.word = word;
        exp_q.push_back(e);
    endtask

    // One clock cycle with the given inputs; the read response is checked
    // on the following falling edge.
    task automatic applyStimulus(input logic ld, input logic [AW-1:0] wp,
                                 input opcode_t op,
                                 input logic signed [OP_WIDTH-1:0] a,
                                 input logic signed [OP_WIDTH-1:0] b,
                                 input logic rd, input logic [AW-1:0] rp,
                                 input logic clr);
        exp_t e;
        load_en       = ld;
        write_pointer = wp;
        opcode        = op;
        operand_a     = a;
        operand_b     = b;
        rd_en         = rd;
        read_pointer  = rp;
        clear         = clr;
        @(posedge clk);
        @(negedge clk);
        if (rd) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("[TB] FAIL sb_empty observed=read expected=queued_entry");
            end else begin
                e = exp_q.pop_front();
                checkOutput($sformatf("rd_valid[%0d]", rp), ENTRY_W'(rd_valid), ENTRY_W'(1));
                checkOutput($sformatf("entry_valid[%0d]", rp), ENTRY_W'(entry_valid), ENTRY_W'(e.ev));
                checkOutput($sformatf("word[%0d]", rp), instruction_word, e.word);
            end
        end else begin
            checkOutput("rd_valid_idle", ENTRY_W'(rd_valid), '0);
        end
    endtask

    task automatic doWrite(input logic [AW-1:0] ptr, input opcode_t op,
                           input logic signed [OP_WIDTH-1:0] a,
                           input logic signed [OP_WIDTH-1:0] b);
        applyStimulus(1'b1, ptr, op, a, b, 1'b0, '0, 1'b0);
    endtask

    task automatic doRead(input logic [AW-1:0] ptr, input logic ev,
                          input logic [ENTRY_W-1:0] word);
        expectRead(ev, word);
        applyStimulus(1'b0, '0, ZERO, 0, 0, 1'b1, ptr, 1'b0);
    endtask

    task automatic doIdle();
        applyStimulus(1'b0, '0, ZERO, 0, 0, 1'b0, '0, 1'b0);
    endtask

    task automatic checkCount(input string tag, input int n);
        checkOutput(tag, ENTRY_W'(write_count), ENTRY_W'(n));
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset_n       = 1'b0;
        load_en       = 1'b0;
        write_pointer = '0;
        opcode        = ZERO;
        operand_a     = '0;
        operand_b     = '0;
        clear         = 1'b0;
        rd_en         = 1'b0;
        read_pointer  = '0;

        #2;
        checkOutput("reset_rd_valid", ENTRY_W'(rd_valid), '0);
        checkOutput("reset_entry_valid", ENTRY_W'(entry_valid), '0);
        checkOutput("reset_word", instruction_word, '0);
        checkCount("reset_count", 0);
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] reading every entry after reset");
        for (int i = 0; i < DEPTH; i++) doRead(AW'(i), 1'b0, '0);
        checkCount("count_after_reset", 0);

        $display("[TB] ALU operations");
        doWrite(5'd3, ADD, -7, 5);
        doIdle();
        checkCount("count_add", 1);
        doRead(5'd3, 1'b1, make_word(ADD, -7, 5, -2, 1'b0));

        doWrite(5'd4, MULT, 32'sh8000_0000, 32'sh8000_0000);
        doIdle();
        doRead(5'd4, 1'b1, make_word(MULT, 32'sh8000_0000, 32'sh8000_0000,
                                     64'sh4000_0000_0000_0000, 1'b0));

        doWrite(5'd6, DIV, -7, 2);
        doWrite(5'd7, MOD, -7, 2);
        doWrite(5'd8, DIV, 9, 0);
        doWrite(5'd9, SUB, 3, 10);
        doWrite(5'd10, ZERO, 5, 6);
        doWrite(5'd11, MOD, 7, -2);
        doIdle();
        doRead(5'd6, 1'b1, make_word(DIV, -7, 2, -3, 1'b0));
        doRead(5'd7, 1'b1, make_word(MOD, -7, 2, -1, 1'b0));
        doRead(5'd8, 1'b1, make_word(DIV, 9, 0, 0, 1'b1));
        doRead(5'd9, 1'b1, make_word(SUB, 3, 10, -7, 1'b0));
        doRead(5'd10, 1'b1, make_word(ZERO, 5, 6, 0, 1'b0));
        doRead(5'd11, 1'b1, make_word(MOD, 7, -2, 1, 1'b0));
        checkCount("count_alu", 8);

        $display("[TB] back-to-back writes with write-first read");
        doWrite(5'd5, PASSA, 11, 0);
        doWrite(5'd5, PASSB, 0, 22);
        doRead(5'd5, 1'b1, make_word(PASSB, 0, 22, 22, 1'b0));
        checkCount("count_b2b", 9);
        doRead(5'd5, 1'b1, make_word(PASSB, 0, 22, 22, 1'b0));

        $display("[TB] fill and saturate");
        for (int i = 0; i < DEPTH; i++) doWrite(AW'(i), PASSA, 100 + i, 0);
        doIdle();
        checkCount("count_full", DEPTH);
        doWrite(5'd0, PASSA, 500, 0);
        doIdle();
        checkCount("count_saturate", DEPTH);
        doRead(5'd0, 1'b1, make_word(PASSA, 500, 0, 500, 1'b0));
        doRead(5'd3, 1'b1, make_word(PASSA, 103, 0, 103, 1'b0));

        $display("[TB] clear with pending commit and concurrent capture");
        doWrite(5'd2, PASSB, 0, 77);
        applyStimulus(1'b1, 5'd9, PASSA, 33, 0, 1'b0, '0, 1'b1);
        checkCount("count_clear", 0);
        doIdle();
        checkCount("count_after_clear_capture", 1);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 9) doRead(AW'(i), 1'b1, make_word(PASSA, 33, 0, 33, 1'b0));
            else        doRead(AW'(i), 1'b0, '0);
        end

        $display("[TB] asynchronous reset mid-pipeline");
        expectRead(1'b1, make_word(PASSA, 33, 0, 33, 1'b0));
        applyStimulus(1'b1, 5'd1, PASSA, 44, 0, 1'b1, 5'd9, 1'b0);
        load_en = 1'b0;
        rd_en   = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rd_valid", ENTRY_W'(rd_valid), '0);
        checkOutput("async_entry_valid", ENTRY_W'(entry_valid), '0);
        checkOutput("async_word", instruction_word, '0);
        checkCount("async_count", 0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        doIdle();
        doIdle();
        checkCount("count_post_reset", 0);
        doRead(5'd1, 1'b0, '0);
        doRead(5'd9, 1'b0, '0);

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL sb_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
